// File: rtl/sim_run_controller.sv
// sim_run_controller
//
// Run controller for the RV32I pipelined core in simulation and FPGA tops. Holds the core in
// reset for RESET_CYCLES cycles, then lets it run while counting cycles and retired
// instructions. The program ends the run by storing an odd value to TOHOST_ADDR: a value of 1
// means pass, any other odd value means fail with exit_code = value >> 1. A watchdog ends the
// run after TIMEOUT_CYCLES run cycles (0 disables it). DONE is terminal until reset.
//
// Optional feature (define SIM_RUN_CONTROLLER_CONSOLE_EN): stores to CONSOLE_ADDR during RUN
// push st_data[7:0] into a CON_DEPTH-deep byte FIFO drained through con_valid/con_ready.
// Without the macro the console outputs are tied to 0.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   core_reset     out  reset to the core; high in HOLD and DONE
//   st_valid       in   core store issued this cycle
//   st_addr        in   store byte address
//   st_data        in   store data
//   retire_valid   in   one instruction retired this cycle
//   cycle_count    out  RUN cycles elapsed (saturating)
//   instret_count  out  instructions retired in RUN (saturating)
//   done           out  run finished, sticky
//   pass           out  tohost value == 1, sticky
//   fail           out  tohost odd value != 1, sticky
//   timeout        out  watchdog expired, sticky
//   exit_code      out  st_data[XLEN-1:1] captured at completion
//   con_valid      out  console byte available
//   con_data       out  console head byte
//   con_ready      in   consumer accepts the head byte
//   con_overflow   out  console byte dropped, sticky

module sim_run_controller #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     CNT_WIDTH      = 32,
    parameter int unsigned     RESET_CYCLES   = 4,
    parameter int unsigned     TIMEOUT_CYCLES = 15,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [XLEN-1:0] CONSOLE_ADDR   = 32'h0000_1004,
    parameter int unsigned     CON_DEPTH      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 core_reset,
    input  logic                 st_valid,
    input  logic [XLEN-1:0]      st_addr,
    input  logic [XLEN-1:0]      st_data,
    input  logic                 retire_valid,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [XLEN-2:0]      exit_code,
    output logic                 con_valid,
    output logic [7:0]           con_data,
    input  logic                 con_ready,
    output logic                 con_overflow
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    // Truncation when TIMEOUT_CYCLES == 0 is harmless: the compare is gated by WD_EN.
    localparam logic [CNT_WIDTH-1:0] WD_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit                   WD_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              in_run;
    logic              tohost_hit;
    logic              wd_hit;

    assign in_run     = (state == StRun);
    assign tohost_hit = in_run && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
    assign wd_hit     = WD_EN && in_run && (cycle_count == WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= StHold;
            hold_cnt      <= '0;
            core_reset    <= 1'b1;
            cycle_count   <= '0;
            instret_count <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= '0;
        end else begin
            case (state)
                StHold: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= StRun;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                StRun: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    if (retire_valid && (instret_count != '1)) begin
                        instret_count <= instret_count + CNT_WIDTH'(1);
                    end
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (tohost_hit) begin
                        state      <= StDone;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        exit_code  <= st_data[XLEN-1:1];
                        if (st_data == XLEN'(1)) begin
                            pass <= 1'b1;
                        end else begin
                            fail <= 1'b1;
                        end
                    end else if (wd_hit) begin
                        state      <= StDone;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                    end
                end
                StDone: begin
                    core_reset <= 1'b1;
                end
                default: begin
                    state      <= StHold;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef SIM_RUN_CONTROLLER_CONSOLE_EN
    localparam int unsigned PTR_W = $clog2(CON_DEPTH);

    logic [7:0]     con_mem [CON_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           con_full;
    logic           con_push;
    logic           con_pop;
    logic           con_write;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign con_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign con_valid = (wr_ptr != rd_ptr);
    assign con_data  = con_mem[rd_ptr[PTR_W-1:0]];
    assign con_push  = in_run && st_valid && (st_addr == CONSOLE_ADDR);
    assign con_pop   = con_valid && con_ready;
    // When full, a simultaneous pop frees the head slot, which is the one being written.
    assign con_write = con_push && (!con_full || con_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            con_overflow <= 1'b0;
        end else begin
            if (con_write) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (con_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (con_push && con_full && !con_pop) begin
                con_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (con_write) begin
            con_mem[wr_ptr[PTR_W-1:0]] <= st_data[7:0];
        end
    end
`else
    logic unused_con_ready;

    assign unused_con_ready = con_ready;
    assign con_valid        = 1'b0;
    assign con_data         = 8'h00;
    assign con_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// Scoreboard bench for sim_run_controller (default parameters). Stimulus pushes the expected
// completion record / console bytes into queues; a monitor pops and compares whenever done
// rises or a console byte is handed over.

module tb_sim_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        core_reset;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        retire_valid = 1'b0;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic        done, pass, fail, timeout;
    logic [30:0] exit_code;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        con_overflow;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [30:0] exit_code;
        logic [31:0] instret;
        logic [31:0] cycles;
    } exp_t;

    exp_t       done_q[$];
    logic [7:0] con_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic       done_prev = 1'b0;

    sim_run_controller dut (
        .clock         (clock),
        .reset         (reset),
        .core_reset    (core_reset),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .retire_valid  (retire_valid),
        .cycle_count   (cycle_count),
        .instret_count (instret_count),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .exit_code     (exit_code),
        .con_valid     (con_valid),
        .con_data      (con_data),
        .con_ready     (con_ready),
        .con_overflow  (con_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives inputs for the next rising edge.
    task automatic cyc(input logic sv, input logic [31:0] a, input logic [31:0] d,
                       input logic r);
        @(negedge clock);
        #1;
        st_valid     = sv;
        st_addr      = a;
        st_data      = d;
        retire_valid = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic push_done(input logic p, input logic f, input logic t, input logic [30:0] ec,
                             input logic [31:0] ir, input logic [31:0] cc);
        exp_t e;
        e.pass = p; e.fail = f; e.timeout = t; e.exit_code = ec; e.instret = ir; e.cycles = cc;
        done_q.push_back(e);
    endtask

    // Asserts reset, checks the asynchronous clear before any clock edge, then releases.
    task automatic apply_reset(input string tag);
        @(negedge clock);
        #1;
        reset        = 1'b1;
        st_valid     = 1'b0;
        retire_valid = 1'b0;
        #1;
        check({tag, "/core_reset"}, core_reset, 1);
        check({tag, "/done"}, done, 0);
        check({tag, "/flags"}, {pass, fail, timeout}, 0);
        check({tag, "/exit_code"}, exit_code, 0);
        check({tag, "/cycle_count"}, cycle_count, 0);
        check({tag, "/instret_count"}, instret_count, 0);
        check({tag, "/con"}, {con_valid, con_overflow}, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (done && !done_prev) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = done_q.pop_front();
                    check("sb_pass", pass, e.pass);
                    check("sb_fail", fail, e.fail);
                    check("sb_timeout", timeout, e.timeout);
                    check("sb_exit_code", exit_code, e.exit_code);
                    check("sb_instret", instret_count, e.instret);
                    check("sb_cycles", cycle_count, e.cycles);
                    check("sb_core_reset", core_reset, 1);
                end
            end
            done_prev = done;
            if (con_valid && con_ready) begin
                if (con_q.size() == 0) check("unexpected_con_byte", con_valid, 0);
                else check("con_byte", con_data, con_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation still running at 50000, expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Power-on: core_reset falls on the 4th edge, then cycle_count counts 1, 2, 3.
        apply_reset("por");
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("hold_core_reset_%0d", k), core_reset, (k < 4) ? 1 : 0);
            check($sformatf("hold_cycle_count_%0d", k), cycle_count, 0);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("run_cycle_count_%0d", k), cycle_count, k);
        end
        // cycle_count == 3 now; three retires then a passing tohost store at cc 6.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1);
        push_done(1'b1, 1'b0, 1'b0, 31'd0, 32'd3, 32'd7);
        cyc(1'b1, 32'h1000, 32'h1, 1'b0);
        idle(4);
        check("done_frozen_cycles", cycle_count, 7);
        check("done_frozen_instret", instret_count, 3);
        check("done_core_reset", core_reset, 1);
        // A store in DONE must not touch the sticky flags.
        cyc(1'b1, 32'h1000, 32'h3, 1'b1);
        idle(2);
        check("done_store_ignored", {pass, fail, instret_count}, {2'b10, 32'd3});

        // Reset from DONE; stores and retires in HOLD ignored; even tohost store ignored.
        apply_reset("in_done");
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1000, 32'h1, 1'b1);
        cyc(1'b1, 32'h1000, 32'h2, 1'b0);
        cyc(1'b1, 32'h1004, 32'h41, 1'b1);
        push_done(1'b0, 1'b1, 1'b0, 31'd21, 32'd1, 32'd3);
        cyc(1'b1, 32'h1000, 32'h2B, 1'b0);
        idle(2);
`ifdef SIM_RUN_CONTROLLER_CONSOLE_EN
        check("console_one_byte", {con_valid, con_data}, {1'b1, 8'h41});
`else
        check("console_disabled", {con_valid, con_data, con_overflow}, 0);
`endif

        // Reset from DONE, run five retiring cycles, then reset mid-RUN.
        apply_reset("after_fail");
        idle(3);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1);
        @(posedge clock);
        #1;
        check("pre_reset_cycles", cycle_count, 5);
        check("pre_reset_instret", instret_count, 5);
        apply_reset("mid_run");

        // Watchdog: no tohost store, two retires.
        idle(3);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        push_done(1'b0, 1'b0, 1'b1, 31'd0, 32'd2, 32'd15);
        n = 0;
        while (!done && n < 40) begin
            idle(1);
            n++;
        end
        check("timeout_reached", done, 1);
        idle(2);

        // Completion in the watchdog cycle wins.
        apply_reset("after_timeout");
        idle(3);
        idle(14);
        push_done(1'b1, 1'b0, 1'b0, 31'd0, 32'd0, 32'd15);
        cyc(1'b1, 32'h1000, 32'h1, 1'b0);
        idle(3);
        check("race_no_timeout", timeout, 0);

`ifdef SIM_RUN_CONTROLLER_CONSOLE_EN
        // Nine bytes into an 8-deep FIFO with no consumer: "I" dropped.
        apply_reset("after_race");
        idle(3);
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) con_q.push_back(8'h41 + 8'(i));
            cyc(1'b1, 32'h1004, 32'h41 + 32'(i), 1'b0);
        end
        idle(1);
        check("con_overflow_set", con_overflow, 1);
        // The watchdog fires during the drain; the FIFO keeps draining in DONE.
        push_done(1'b0, 1'b0, 1'b1, 31'd0, 32'd0, 32'd15);
        con_ready = 1'b1;
        idle(12);
        check("con_drained", con_valid, 0);
        check("con_overflow_sticky", con_overflow, 1);
        con_ready = 1'b0;
`endif

        idle(2);
        check("done_queue_empty", done_q.size(), 0);
        check("con_queue_empty", con_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
